// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
//
// Single-master I2C bus controller. A host command (start, 7-bit address,
// rd_wr, data byte) is turned into open-drain SCL/SDA traffic. The master only
// ever pulls a line low or releases it; external pull-ups supply the 1.
//
// Every bus bit is four quarters of QTR clk cycles:
//   q0: SCL low, SDA updated    q1: SCL released
//   q2: SCL high, SDA sampled   q3: SCL low
// SCL is never read back, so slave clock stretching is not supported.
//
// Parameters
//   QTR      system clocks per quarter SCL bit (one bit = 4*QTR clk)
//
// Ports
//   clk      system clock, all logic on the rising edge
//   reset    asynchronous, active-high reset
//   start    level, sampled in IDLE; high begins a transaction
//   stop     level, sampled at the end of each data byte; high ends it
//   rd_wr    1 = read, 0 = write; latched at start
//   address  7-bit slave address; latched at start
//   din      write data; latched at start and before each further write byte
//   dout     last byte read from the slave
//   SDA      open-drain data line (driven 0 or z)
//   SCL      open-drain clock line (driven 0 or z)
// -----------------------------------------------------------------------------
module i2c_master #(
  parameter int QTR = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       rd_wr,
  input  logic [6:0] address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  inout  wire        SDA,
  inout  wire        SCL
);

  // Quarter-timer width; kept at least 1 bit so QTR=1 still elaborates.
  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WR_ACK,
    S_READ,
    S_RD_ACK,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [QW-1:0]   r_qcnt;    // clk count inside the current quarter
  logic [1:0]      r_q;       // quarter index inside the current bit
  logic [2:0]      r_bit;     // bit index inside the current byte
  logic [7:0]      r_tx;      // outgoing shift register, MSB on the bus
  logic [7:0]      r_rx;      // incoming shift register
  logic [7:0]      r_din;     // first write byte, captured with the command
  logic [7:0]      r_dout;
  logic            r_rw;
  logic            r_ack;     // SDA level seen in the last ACK slot
  logic            r_stop;    // stop request captured at the end of a byte

  logic            w_qtick;   // last clk of a quarter
  logic            w_sample;  // last clk of q2: SDA is sampled here
  logic            w_bit_end; // last clk of q3: bit boundary
  logic            w_last_bit;
  logic            w_scl_phase_low;
  logic            w_sda_low;
  logic            w_scl_low;
  logic            w_sda_in;

  assign w_qtick         = (r_qcnt == QW'(QTR - 1));
  assign w_sample        = w_qtick && (r_q == 2'd2) && (r_state != S_IDLE);
  assign w_bit_end       = w_qtick && (r_q == 2'd3) && (r_state != S_IDLE);
  assign w_last_bit      = (r_bit == 3'd7);
  assign w_scl_phase_low = (r_q == 2'd0) || (r_q == 2'd3);

  // Open-drain pads: pull low or release, never drive a 1.
  assign SDA      = w_sda_low ? 1'b0 : 1'bz;
  assign SCL      = w_scl_low ? 1'b0 : 1'bz;
  // SDA is sampled directly: the slave only changes it while SCL is low,
  // so it is stable for the whole high phase in which sampling happens.
  assign w_sda_in = SDA;
  assign dout     = r_dout;

  // ---------------------------------------------------------------------------
  // Next-state decode. Transitions happen only on bit boundaries (except the
  // IDLE -> START launch), so every state lasts a whole number of bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves it unassigned and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_START;
      S_START:    if (w_bit_end) w_state_nxt = S_ADDR;
      S_ADDR:     if (w_bit_end && w_last_bit) w_state_nxt = S_ADDR_ACK;
      S_ADDR_ACK: if (w_bit_end) begin
                    if (r_ack)     w_state_nxt = S_STOP;
                    else if (r_rw) w_state_nxt = S_READ;
                    else           w_state_nxt = S_WRITE;
                  end
      S_WRITE:    if (w_bit_end && w_last_bit) w_state_nxt = S_WR_ACK;
      S_WR_ACK:   if (w_bit_end) w_state_nxt = (r_ack || r_stop) ? S_STOP : S_WRITE;
      S_READ:     if (w_bit_end && w_last_bit) w_state_nxt = S_RD_ACK;
      S_RD_ACK:   if (w_bit_end) w_state_nxt = r_stop ? S_STOP : S_READ;
      S_STOP:     if (w_bit_end) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus line decode from state and quarter.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sda_low = 1'b0;
    w_scl_low = 1'b0;
    case (r_state)
      S_START: begin
        // q0 both released, q1/q2 SDA falls under a high SCL, q3 SCL low.
        w_sda_low = (r_q != 2'd0);
        w_scl_low = (r_q == 2'd3);
      end
      S_ADDR, S_WRITE: begin
        w_sda_low = ~r_tx[7];
        w_scl_low = w_scl_phase_low;
      end
      S_ADDR_ACK, S_WR_ACK, S_READ: begin
        w_scl_low = w_scl_phase_low;
      end
      S_RD_ACK: begin
        // Release (NACK) when the host asked to stop, otherwise ACK.
        w_sda_low = ~r_stop;
        w_scl_low = w_scl_phase_low;
      end
      S_STOP: begin
        // q0 SDA low under low SCL, q1 SCL released, q2 SDA rises under high SCL.
        w_sda_low = (r_q <= 2'd1);
        w_scl_low = (r_q == 2'd0);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, timing and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_qcnt  <= '0;
      r_q     <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_rw    <= 1'b0;
      r_ack   <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from pre-edge values regardless of statement order.
      r_state <= w_state_nxt;

      // Quarter timer runs only while a transaction is active; holding it at
      // zero in IDLE makes START begin cleanly at q0.
      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_q    <= '0;
        r_bit  <= '0;
        if (start) begin
          r_tx  <= {address, rd_wr};
          r_rw  <= rd_wr;
          r_din <= din;
        end
      end else if (w_qtick) begin
        r_qcnt <= '0;
        r_q    <= r_q + 2'd1;
      end else begin
        r_qcnt <= r_qcnt + 1'b1;
      end

      if (w_sample) begin
        case (r_state)
          S_ADDR_ACK, S_WR_ACK: r_ack <= w_sda_in;
          S_READ: begin
            r_rx <= {r_rx[6:0], w_sda_in};
            if (w_last_bit) r_dout <= {r_rx[6:0], w_sda_in};
          end
          default: ;
        endcase
      end

      if (w_bit_end) begin
        case (r_state)
          S_ADDR, S_WRITE: begin
            r_tx  <= {r_tx[6:0], 1'b0};
            r_bit <= r_bit + 3'd1;
            if (r_state == S_WRITE && w_last_bit) r_stop <= stop;
          end
          S_READ: begin
            r_bit <= r_bit + 3'd1;
            if (w_last_bit) r_stop <= stop;
          end
          // First data byte comes from the copy taken with the command;
          // later bytes take din as it stands at the end of the ACK slot.
          S_ADDR_ACK: r_tx <= r_din;
          S_WR_ACK:   r_tx <= din;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master
//
// Self-checking bench for i2c_master (QTR=1). A behavioural I2C slave at
// 7'h50 sits on the pulled-up bus; it watches SCL/SDA on the falling clk edge,
// ACKs its own address, ACKs write bytes and returns 8'h3C on reads.
// Expected address/data bytes and read results are queued when a transaction
// is launched and popped when the slave (or dout) produces them.
// -----------------------------------------------------------------------------
module tb_i2c_master;

  localparam logic [6:0] SLV_ADDR = 7'h50;
  localparam logic [7:0] SLV_TX   = 8'h3C;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       rd_wr;
  logic [6:0] address;
  logic [7:0] din;
  logic [7:0] dout;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  i2c_master #(.QTR(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .rd_wr   (rd_wr),
    .address (address),
    .din     (din),
    .dout    (dout),
    .SDA     (sda),
    .SCL     (scl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic sb_check(input string tag, input logic [7:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got 0x%02h, expected nothing queued", tag, got);
    end else begin
      check(tag, {24'h0, got}, {24'h0, exp_q.pop_front()});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural slave
  // ---------------------------------------------------------------------------
  typedef enum {SL_IDLE, SL_ADDR, SL_ADDR_ACK, SL_WR, SL_WR_ACK, SL_RD, SL_RD_ACK} sl_ph_t;

  sl_ph_t     s_ph = SL_IDLE;
  logic       s_drv = 1'b0;
  logic [7:0] s_sh = '0;
  logic [7:0] s_tx = '0;
  int         s_cnt = 0;
  logic       s_match = 1'b0;
  logic       s_rw = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       sda_v;
  logic       scl_v;
  logic       addr_ack_bus = 1'b0;
  logic       wr_ack_bus = 1'b0;
  logic       m_ack_bus = 1'b0;
  int         start_cyc = 0;
  int         stop_cyc = 0;
  int         stop_cnt = 0;

  assign sda = s_drv ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    sda_v = sda;
    scl_v = scl;
    if (scl_v && p_scl && p_sda && !sda_v) begin
      s_ph = SL_ADDR; s_cnt = 0; s_sh = '0; s_drv = 1'b0; start_cyc = cyc;
    end else if (scl_v && p_scl && !p_sda && sda_v) begin
      s_ph = SL_IDLE; s_drv = 1'b0; stop_cyc = cyc; stop_cnt++;
    end else if (scl_v && !p_scl) begin
      case (s_ph)
        SL_ADDR, SL_WR: begin s_sh = {s_sh[6:0], sda_v}; s_cnt++; end
        SL_ADDR_ACK:    addr_ack_bus = sda_v;
        SL_WR_ACK:      wr_ack_bus = sda_v;
        SL_RD_ACK:      m_ack_bus = sda_v;
        default: ;
      endcase
    end else if (!scl_v && p_scl) begin
      case (s_ph)
        SL_ADDR: if (s_cnt == 8) begin
          sb_check("addr_byte", s_sh);
          s_match = (s_sh[7:1] == SLV_ADDR);
          s_rw    = s_sh[0];
          s_drv   = s_match;
          s_ph    = SL_ADDR_ACK;
        end
        SL_ADDR_ACK: begin
          s_cnt = 0; s_sh = '0;
          if (!s_match) begin
            s_drv = 1'b0; s_ph = SL_IDLE;
          end else if (s_rw) begin
            s_tx = SLV_TX; s_drv = !s_tx[7]; s_ph = SL_RD;
          end else begin
            s_drv = 1'b0; s_ph = SL_WR;
          end
        end
        SL_WR: if (s_cnt == 8) begin
          sb_check("wr_byte", s_sh);
          s_drv = 1'b1; s_ph = SL_WR_ACK;
        end
        SL_WR_ACK: begin s_drv = 1'b0; s_cnt = 0; s_ph = SL_WR; end
        SL_RD: begin
          s_cnt++;
          s_tx = {s_tx[6:0], 1'b0};
          if (s_cnt == 8) begin s_drv = 1'b0; s_ph = SL_RD_ACK; end
          else s_drv = !s_tx[7];
        end
        SL_RD_ACK: begin
          if (!m_ack_bus) begin s_tx = SLV_TX; s_cnt = 0; s_drv = !s_tx[7]; s_ph = SL_RD; end
          else begin s_drv = 1'b0; s_ph = SL_IDLE; end
        end
        default: ;
      endcase
    end
    p_scl = scl_v;
    p_sda = sda_v;
  end

  // ---------------------------------------------------------------------------
  // Host-side helpers
  // ---------------------------------------------------------------------------
  int t_acc = 0;
  int stop_base = 0;

  task automatic launch(input logic [6:0] a, input logic rw, input logic [7:0] d, input logic stp);
    @(negedge clk);
    address = a; rd_wr = rw; din = d; stop = stp; start = 1'b1;
    stop_base = stop_cnt;
    @(posedge clk);
    #1;
    t_acc = cyc;
    start = 1'b0;
  endtask

  // exp_len: clk edges from start acceptance to the STOP condition (SDA rising
  // in q2 of STOP); IDLE follows two cycles later.
  task automatic wait_stop(input string tag, input int exp_len);
    for (int i = 0; i < 1000 && stop_cnt == stop_base; i++) @(posedge clk);
    check({tag, "_done"}, stop_cnt, stop_base + 1);
    if (stop_cnt != stop_base) check({tag, "_stop_time"}, stop_cyc - t_acc, exp_len);
    repeat (3) @(posedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; rd_wr = 1'b0; address = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sda", sda, 1);
    check("rst_scl", scl, 1);
    check("rst_dout", dout, 8'h00);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single write: 4 START + 36 addr/ack + 36 data/ack, STOP edge at 78.
    exp_q.push_back({SLV_ADDR, 1'b0});
    exp_q.push_back(8'hA5);
    addr_ack_bus = 1'b1; wr_ack_bus = 1'b1;
    launch(SLV_ADDR, 1'b0, 8'hA5, 1'b1);
    wait_stop("wr1", 78);
    check("wr1_start_lat", start_cyc - t_acc, 1);
    check("wr1_addr_ack", addr_ack_bus, 0);
    check("wr1_data_ack", wr_ack_bus, 0);

    // Single read: slave returns 8'h3C, master NACKs because stop=1.
    exp_q.push_back({SLV_ADDR, 1'b1});
    exp_q.push_back(SLV_TX);
    addr_ack_bus = 1'b1; m_ack_bus = 1'b0;
    launch(SLV_ADDR, 1'b1, 8'h00, 1'b1);
    wait_stop("rd1", 78);
    sb_check("rd1_dout", dout);
    check("rd1_addr_ack", addr_ack_bus, 0);
    check("rd1_master_nack", m_ack_bus, 1);

    // Address NACK: STOP straight after the ACK slot (4+36 then STOP q2 = 42).
    exp_q.push_back({7'h11, 1'b0});
    addr_ack_bus = 1'b0;
    launch(7'h11, 1'b0, 8'hFF, 1'b1);
    wait_stop("nack", 42);
    check("nack_ack_slot", addr_ack_bus, 1);
    check("nack_dout_hold", dout, 8'h3C);

    // Two-byte write: stop=0 at the end of byte 1, then din/stop changed
    // during byte 1's ACK slot (edge 74) so byte 2 is 8'h34 and ends it.
    exp_q.push_back({SLV_ADDR, 1'b0});
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    wr_ack_bus = 1'b1;
    launch(SLV_ADDR, 1'b0, 8'h12, 1'b0);
    repeat (74) @(posedge clk);
    #1;
    din = 8'h34; stop = 1'b1;
    wait_stop("multi", 114);
    check("multi_data_ack", wr_ack_bus, 0);

    // Reset during the 4th address bit (q0, SCL low, SDA = address bit 3 = 0).
    launch(SLV_ADDR, 1'b0, 8'h77, 1'b1);
    repeat (16) @(posedge clk);
    #2;
    check("mid_sda_low", sda, 0);
    check("mid_scl_low", scl, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_sda", sda, 1);
    check("mid_rst_scl", scl, 1);
    check("mid_rst_dout", dout, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // Clean transaction after the aborted one.
    exp_q.push_back({SLV_ADDR, 1'b0});
    exp_q.push_back(8'hC3);
    launch(SLV_ADDR, 1'b0, 8'hC3, 1'b1);
    wait_stop("post_rst", 78);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
